// File: rtl/avmm_pio_pkg.sv
// Shared definitions for the Avalon-MM output PIO family: register map,
// STATUS layout and parameter limits.
package avmm_pio_pkg;

    typedef enum logic [2:0] {
        ADDR_DATA   = 3'd0,
        ADDR_SET    = 3'd1,
        ADDR_CLR    = 3'd2,
        ADDR_TOGGLE = 3'd3,
        ADDR_MASK   = 3'd4,
        ADDR_LEN    = 3'd5,
        ADDR_STATUS = 3'd6,
        ADDR_RSVD   = 3'd7
    } addr_e;

    localparam int unsigned STATUS_BUSY_BIT  = 0;
    localparam int unsigned STATUS_WIDTH_LSB = 8;
    localparam int unsigned STATUS_WIDTH_W   = 8;

    localparam int unsigned DATA_W_MAX = 32;
    localparam int unsigned CNT_W_MAX  = 32;

    function automatic bit width_ok(input int unsigned w, input int unsigned max_w);
        return (w >= 1) && (w <= max_w);
    endfunction

endpackage

// File: rtl/pio_pulse_timer.sv
// Shared pulse-length down-counter: loads on trigger, counts to zero and
// flags the last cycle so the owner can clear its pulsed bits.
module pio_pulse_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire,
    output logic             busy
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // A reload on the final cycle wins over the expiry clear.
    assign expire = (cnt_q == CNT_W'(1)) && !load;
    assign busy   = (cnt_q != '0);

endmodule

// File: rtl/avmm_pio_out_pulse.sv
// Avalon-MM output PIO with atomic SET/CLR/TOGGLE, registered readback and
// per-bit auto-clear pulse mode sharing one programmable counter.
module avmm_pio_out_pulse
    import avmm_pio_pkg::*;
#(
    parameter int unsigned          DATA_W    = 2,
    parameter logic [DATA_W-1:0]    RESET_VAL = '0,
    parameter int unsigned          CNT_W     = 16,
    parameter bit                   PULSE_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic              read_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_port,
    output logic              pulse_busy
);

    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_wr;
    logic [DATA_W-1:0] data_d;
    logic              data_write;
    logic [DATA_W-1:0] mask_q;
    logic [CNT_W-1:0]  len_q;
    logic              load;
    logic              expire;
    logic              busy;
    logic [31:0]       rdata_mux;
    logic              unused_wd;

    assign wr_acc    = chipselect && !write_n;
    assign rd_acc    = chipselect && !read_n;
    assign wd        = writedata[DATA_W-1:0];
    assign unused_wd = ^writedata;

    always_comb begin
        data_wr    = data_q;
        data_write = 1'b0;
        if (wr_acc) begin
            case (addr_e'(address))
                ADDR_DATA:   begin data_wr = wd;             data_write = 1'b1; end
                ADDR_SET:    begin data_wr = data_q | wd;    data_write = 1'b1; end
                ADDR_CLR:    begin data_wr = data_q & ~wd;   data_write = 1'b1; end
                ADDR_TOGGLE: begin data_wr = data_q ^ wd;    data_write = 1'b1; end
                default:     ;
            endcase
        end
    end

    // Bus writes take priority over the expiry clear in the same cycle.
    always_comb begin
        data_d = data_q;
        if (data_write) begin
            data_d = data_wr;
        end else if (expire) begin
            data_d = data_q & ~mask_q;
        end
    end

    assign load = PULSE_EN && data_write && (len_q != '0) && ((data_wr & mask_q) != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    generate
        if (PULSE_EN) begin : g_pulse
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    mask_q <= '0;
                    len_q  <= '0;
                end else if (wr_acc) begin
                    if (addr_e'(address) == ADDR_MASK) mask_q <= wd;
                    if (addr_e'(address) == ADDR_LEN)  len_q  <= writedata[CNT_W-1:0];
                end
            end

            pio_pulse_timer #(
                .CNT_W (CNT_W)
            ) u_timer (
                .clk      (clk),
                .reset_n  (reset_n),
                .load     (load),
                .load_val (len_q),
                .expire   (expire),
                .busy     (busy)
            );
        end else begin : g_no_pulse
            assign mask_q = '0;
            assign len_q  = '0;
            assign expire = 1'b0;
            assign busy   = 1'b0;
        end
    endgenerate

    always_comb begin
        rdata_mux = '0;
        case (addr_e'(address))
            ADDR_DATA: rdata_mux = 32'(data_q);
            ADDR_MASK: rdata_mux = 32'(mask_q);
            ADDR_LEN:  rdata_mux = 32'(len_q);
            ADDR_STATUS: begin
                rdata_mux[STATUS_BUSY_BIT] = busy;
                rdata_mux[STATUS_WIDTH_LSB +: STATUS_WIDTH_W] = STATUS_WIDTH_W'(DATA_W);
            end
            default:   rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd_acc) begin
            readdata <= rdata_mux;
        end
    end

    assign out_port   = data_q;
    assign pulse_busy = busy;

endmodule

// File: tb/tb_avmm_pio_out_pulse.sv
// Self-checking bench for avmm_pio_out_pulse: register table plus hand-written
// pulse timing, retrigger, expiry-collision and asynchronous reset sequences.
module tb_avmm_pio_out_pulse;

    localparam int unsigned DATA_W = 2;
    localparam logic [1:0]  RST_V  = 2'b10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  out_port;
    logic        pulse_busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd_q[$];

    typedef struct {
        bit          wr;
        bit          rd;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [1:0]  exp_out;
    } vec_t;

    vec_t vecs[$];

    avmm_pio_out_pulse #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RST_V),
        .CNT_W     (16),
        .PULSE_EN  (1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .pulse_busy (pulse_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // One bus cycle; outputs are sampled 1 ns after the edge that accepts it.
    task automatic cyc(input bit wr, input bit rd, input logic [2:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd);
        logic [31:0] e;
        chipselect = wr | rd;
        write_n    = !wr;
        read_n     = !rd;
        address    = a;
        writedata  = wd;
        if (rd) rd_q.push_back(exp_rd);
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        read_n     = 1'b1;
        if (rd) begin
            e = rd_q.pop_front();
            chk($sformatf("readdata@%0d", a), readdata, e);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        cyc(1'b1, 1'b0, a, wd, '0);
    endtask

    task automatic idle_chk(input string name, input logic [1:0] exp_out, input bit exp_busy);
        cyc(1'b0, 1'b0, 3'd0, '0, '0);
        chk({name, "_out"}, 32'(out_port), 32'(exp_out));
        chk({name, "_busy"}, 32'(pulse_busy), 32'(exp_busy));
    endtask

    // After a triggering write: high for len-1 more cycles, then cleared.
    task automatic pulse_track(input string name, input int unsigned len,
                               input logic [1:0] hi, input logic [1:0] lo);
        for (int unsigned i = 1; i < len; i++) idle_chk(name, hi, 1'b1);
        idle_chk({name, "_end"}, lo, 1'b0);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        read_n     = 1'b1;
        writedata  = '0;

        //            wr    rd    addr  wd            exp_rd        exp_out
        vecs.push_back('{1'b1, 1'b0, 3'd0, 32'hFFFF_FFFF, 32'h0,        2'd3});
        vecs.push_back('{1'b0, 1'b1, 3'd0, 32'h0,         32'h3,        2'd3});
        vecs.push_back('{1'b1, 1'b0, 3'd0, 32'h3,         32'h0,        2'd3});
        vecs.push_back('{1'b1, 1'b0, 3'd1, 32'h0,         32'h0,        2'd3});
        vecs.push_back('{1'b1, 1'b0, 3'd2, 32'h1,         32'h0,        2'd2});
        vecs.push_back('{1'b1, 1'b0, 3'd3, 32'h2,         32'h0,        2'd0});
        vecs.push_back('{1'b0, 1'b1, 3'd1, 32'h0,         32'h0,        2'd0});
        vecs.push_back('{1'b0, 1'b1, 3'd0, 32'h0,         32'h0,        2'd0});
        vecs.push_back('{1'b1, 1'b0, 3'd6, 32'hFFFF_FFFF, 32'h0,        2'd0});
        vecs.push_back('{1'b0, 1'b1, 3'd6, 32'h0,         32'h0000_0200, 2'd0});
        vecs.push_back('{1'b1, 1'b0, 3'd7, 32'hFFFF_FFFF, 32'h0,        2'd0});
        vecs.push_back('{1'b0, 1'b1, 3'd7, 32'h0,         32'h0,        2'd0});
        vecs.push_back('{1'b1, 1'b1, 3'd0, 32'h1,         32'h0,        2'd1});
        vecs.push_back('{1'b0, 1'b1, 3'd0, 32'h0,         32'h1,        2'd1});
        vecs.push_back('{1'b1, 1'b0, 3'd0, 32'h0,         32'h0,        2'd0});
        vecs.push_back('{1'b1, 1'b0, 3'd4, 32'hFFFF_FFFF, 32'h0,        2'd0});
        vecs.push_back('{1'b0, 1'b1, 3'd4, 32'h0,         32'h3,        2'd0});
        vecs.push_back('{1'b1, 1'b0, 3'd4, 32'h1,         32'h0,        2'd0});
        vecs.push_back('{1'b1, 1'b0, 3'd5, 32'h1234_0004, 32'h0,        2'd0});
        vecs.push_back('{1'b0, 1'b1, 3'd5, 32'h0,         32'h4,        2'd0});
        vecs.push_back('{1'b0, 1'b1, 3'd4, 32'h0,         32'h1,        2'd0});

        // Reset state
        #12;
        chk("rst_out", 32'(out_port), 32'(RST_V));
        chk("rst_busy", 32'(pulse_busy), 32'h0);
        chk("rst_readdata", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b1, 3'd6, '0, 32'h0000_0200);
        idle_chk("idle", RST_V, 1'b0);
        chk("rd_hold", readdata, 32'h0000_0200);

        // Register table
        foreach (vecs[i]) begin
            cyc(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_out", i), 32'(out_port), 32'(vecs[i].exp_out));
        end

        // Basic pulse: bit1 level, bit0 pulsed for 4 cycles
        wr(3'd0, 32'h2);
        chk("lvl_out", 32'(out_port), 32'h2);
        chk("lvl_busy", 32'(pulse_busy), 32'h0);
        wr(3'd1, 32'h1);
        chk("p1_out", 32'(out_port), 32'h3);
        chk("p1_busy", 32'(pulse_busy), 32'h1);
        cyc(1'b0, 1'b1, 3'd6, '0, 32'h0000_0201);
        pulse_track("p1", 3, 2'd3, 2'd2);
        idle_chk("p1_after", 2'd2, 1'b0);

        // Retrigger two cycles after the first write
        wr(3'd1, 32'h1);
        idle_chk("rt_a", 2'd3, 1'b1);
        wr(3'd1, 32'h1);
        chk("rt_b_out", 32'(out_port), 32'h3);
        pulse_track("rt", 4, 2'd3, 2'd2);

        // Data write on the expiry cycle: write wins, no reload
        wr(3'd1, 32'h1);
        idle_chk("ex_a", 2'd3, 1'b1);
        idle_chk("ex_b", 2'd3, 1'b1);
        idle_chk("ex_c", 2'd3, 1'b1);
        wr(3'd0, 32'h2);
        chk("ex_out", 32'(out_port), 32'h2);
        chk("ex_busy", 32'(pulse_busy), 32'h0);
        idle_chk("ex_after", 2'd2, 1'b0);

        // Write on the expiry cycle that retriggers
        wr(3'd1, 32'h1);
        idle_chk("exr_a", 2'd3, 1'b1);
        idle_chk("exr_b", 2'd3, 1'b1);
        idle_chk("exr_c", 2'd3, 1'b1);
        wr(3'd0, 32'h1);
        chk("exr_out", 32'(out_port), 32'h1);
        chk("exr_busy", 32'(pulse_busy), 32'h1);
        pulse_track("exr", 4, 2'd1, 2'd0);

        // PULSE_LEN=0: masked bit behaves as a level
        wr(3'd5, 32'h0);
        wr(3'd1, 32'h1);
        for (int k = 0; k < 10; k++) idle_chk("lvl0", 2'd1, 1'b0);
        wr(3'd0, 32'h0);

        // Asynchronous reset mid-pulse
        wr(3'd5, 32'h8);
        wr(3'd1, 32'h3);
        idle_chk("ar_pre", 2'd3, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_out", 32'(out_port), 32'(RST_V));
        chk("ar_busy", 32'(pulse_busy), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b1, 3'd4, '0, 32'h0);
        cyc(1'b0, 1'b1, 3'd5, '0, 32'h0);
        idle_chk("ar_after", RST_V, 1'b0);

        chk("sb_empty", 32'(rd_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
